// File: rtl/pkmc_page_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pkmc_page_ctrl
// Purpose  : Open-row SDRAM command sequencer with tRP/tRCD/burst/tRFC spacing
// Revision : 1.0 - initial release
// ============================================================================
module pkmc_page_ctrl #(
    parameter int ROWLEN = 13,
    parameter int COLLEN = 9,
    parameter int TRP    = 2,
    parameter int TRCD   = 2,
    parameter int TBURST = 4,
    parameter int TRFC   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ROWLEN-1:0] req_row,
    input  logic [COLLEN-1:0] req_col,
    input  logic              req_we,
    output logic              req_ready,
    input  logic              ref_req,
    output logic              ref_ack,
    output logic [2:0]        cmd,
    output logic [ROWLEN-1:0] cmd_row,
    output logic [COLLEN-1:0] cmd_col
);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    localparam logic [3:0] CNT_TRP    = 4'(TRP - 1);
    localparam logic [3:0] CNT_TRCD   = 4'(TRCD - 1);
    localparam logic [3:0] CNT_TBURST = 4'(TBURST - 1);
    localparam logic [3:0] CNT_TRFC   = 4'(TRFC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_PRE  = 3'd2,
        S_ACT  = 3'd3,
        S_RW   = 3'd4,
        S_REF  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    state_t              next_q, next_d;
    state_t              issue;
    logic                row_open_q, row_open_d;
    logic [ROWLEN-1:0]   open_row_q, open_row_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [2:0]          cmd_q, cmd_d;
    logic [ROWLEN-1:0]   cmd_row_q, cmd_row_d;
    logic [COLLEN-1:0]   cmd_col_q, cmd_col_d;
    logic                req_ready_q, req_ready_d;
    logic                ref_ack_q, ref_ack_d;
    logic                hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            next_q      <= S_IDLE;
            row_open_q  <= 1'b0;
            open_row_q  <= '0;
            cnt_q       <= 4'd0;
            cmd_q       <= CMD_NOP;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            req_ready_q <= 1'b0;
            ref_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_q      <= next_d;
            row_open_q  <= row_open_d;
            open_row_q  <= open_row_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            cmd_row_q   <= cmd_row_d;
            cmd_col_q   <= cmd_col_d;
            req_ready_q <= req_ready_d;
            ref_ack_q   <= ref_ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        next_d      = next_q;
        row_open_d  = row_open_q;
        open_row_d  = open_row_q;
        cnt_d       = cnt_q;
        cmd_d       = CMD_NOP;
        cmd_row_d   = cmd_row_q;
        cmd_col_d   = cmd_col_q;
        req_ready_d = 1'b0;
        ref_ack_d   = 1'b0;
        issue       = S_IDLE;
        hit         = row_open_q && (open_row_q == req_row);

        // First pick which command (if any) goes out this edge.
        case (state_q)
            S_IDLE: begin
                if (ref_req) begin
                    issue = row_open_q ? S_PRE : S_REF;
                end else if (req_valid) begin
                    if (hit) begin
                        issue = S_RW;
                    end else if (row_open_q) begin
                        issue = S_PRE;
                    end else begin
                        issue = S_ACT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (next_q == S_IDLE) begin
                    state_d = S_IDLE;
                end else begin
                    issue = next_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // PRE is only ever issued from IDLE, so ref_req there tells which
        // sequence it belongs to.
        case (issue)
            S_PRE: begin
                cmd_d      = CMD_PRE;
                row_open_d = 1'b0;
                cnt_d      = CNT_TRP;
                next_d     = ref_req ? S_REF : S_ACT;
                state_d    = S_WAIT;
            end
            S_ACT: begin
                cmd_d      = CMD_ACT;
                row_open_d = 1'b1;
                open_row_d = req_row;
                cmd_row_d  = req_row;
                cnt_d      = CNT_TRCD;
                next_d     = S_RW;
                state_d    = S_WAIT;
            end
            S_RW: begin
                cmd_d       = req_we ? CMD_WR : CMD_RD;
                cmd_col_d   = req_col;
                req_ready_d = 1'b1;
                cnt_d       = CNT_TBURST;
                next_d      = S_IDLE;
                state_d     = S_WAIT;
            end
            S_REF: begin
                cmd_d      = CMD_REF;
                ref_ack_d  = 1'b1;
                row_open_d = 1'b0;
                cnt_d      = CNT_TRFC;
                next_d     = S_IDLE;
                state_d    = S_WAIT;
            end
            default: ;
        endcase
    end

    assign req_ready = req_ready_q;
    assign ref_ack   = ref_ack_q;
    assign cmd       = cmd_q;
    assign cmd_row   = cmd_row_q;
    assign cmd_col   = cmd_col_q;

endmodule
`default_nettype wire

// File: tb/tb_pkmc_page_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkmc_page_ctrl
// Purpose  : Scoreboard bench for the open-row command sequencer
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkmc_page_ctrl;

    localparam int ROWLEN = 13;
    localparam int COLLEN = 9;
    localparam int TRP    = 2;
    localparam int TRCD   = 2;
    localparam int TBURST = 4;
    localparam int TRFC   = 7;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic [ROWLEN-1:0] req_row = '0;
    logic [COLLEN-1:0] req_col = '0;
    logic              req_we = 1'b0;
    logic              req_ready;
    logic              ref_req = 1'b0;
    logic              ref_ack;
    logic [2:0]        cmd;
    logic [ROWLEN-1:0] cmd_row;
    logic [COLLEN-1:0] cmd_col;

    typedef struct {
        int                cyc;
        logic [2:0]        kind;
        logic [ROWLEN-1:0] row;
        logic [COLLEN-1:0] col;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // Bench-side model of the open row and of when IDLE can next sample.
    bit                m_open = 1'b0;
    logic [ROWLEN-1:0] m_row = '0;
    int                next_e0 = 0;

    pkmc_page_ctrl #(
        .ROWLEN(ROWLEN), .COLLEN(COLLEN), .TRP(TRP),
        .TRCD(TRCD), .TBURST(TBURST), .TRFC(TRFC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_row(req_row), .req_col(req_col),
        .req_we(req_we), .req_ready(req_ready),
        .ref_req(ref_req), .ref_ack(ref_ack),
        .cmd(cmd), .cmd_row(cmd_row), .cmd_col(cmd_col)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input logic [2:0] k,
                        input logic [ROWLEN-1:0] r, input logic [COLLEN-1:0] cl);
        exp_t e;
        e.cyc = c; e.kind = k; e.row = r; e.col = cl;
        exp_q.push_back(e);
    endtask

    // Monitor: every non-NOP command pops one expectation; NOP cycles must
    // carry no strobes.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (cmd != CMD_NOP) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", int'(cmd), int'(CMD_NOP));
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd", int'(cmd), int'(e.kind));
                    chk("cmd_cycle", cyc, e.cyc);
                    chk("req_ready", int'(req_ready),
                        int'(e.kind == CMD_RD || e.kind == CMD_WR));
                    chk("ref_ack", int'(ref_ack), int'(e.kind == CMD_REF));
                    if (e.kind == CMD_ACT) chk("cmd_row", int'(cmd_row), int'(e.row));
                    if (e.kind == CMD_RD || e.kind == CMD_WR)
                        chk("cmd_col", int'(cmd_col), int'(e.col));
                end
            end else begin
                chk("nop_strobes", int'({req_ready, ref_ack}), 0);
            end
        end
    end

    task automatic access(input logic [ROWLEN-1:0] r, input logic [COLLEN-1:0] cl,
                          input logic we, input bit with_ref);
        int         e0;
        int         t;
        int         n;
        logic [2:0] rw;
        rw = we ? CMD_WR : CMD_RD;
        req_row = r; req_col = cl; req_we = we; req_valid = 1'b1; ref_req = with_ref;
        e0 = (cyc + 1 > next_e0) ? cyc + 1 : next_e0;
        t  = e0;
        if (with_ref) begin
            if (m_open) begin
                push(t, CMD_PRE, '0, '0);
                t += TRP;
            end
            push(t, CMD_REF, '0, '0);
            t += TRFC + 1;
            m_open = 1'b0;
        end
        if (m_open && m_row == r) begin
            push(t, rw, '0, cl);
        end else begin
            if (m_open) begin
                push(t, CMD_PRE, '0, '0);
                t += TRP;
            end
            push(t, CMD_ACT, r, '0);
            t += TRCD;
            push(t, rw, '0, cl);
        end
        m_open  = 1'b1;
        m_row   = r;
        next_e0 = t + TBURST + 1;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (ref_ack) ref_req = 1'b0;
            if (req_ready) break;
            n++;
        end
        if (n >= 60) chk("ready_timeout", 0, 1);
        req_valid = 1'b0;
        ref_req   = 1'b0;
    endtask

    initial begin
        int e0;
        int n;
        #2;
        chk("rst_cmd", int'(cmd), int'(CMD_NOP));
        chk("rst_cmd_row", int'(cmd_row), 0);
        chk("rst_cmd_col", int'(cmd_col), 0);
        chk("rst_strobes", int'({req_ready, ref_ack}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_cmd", int'(cmd), int'(CMD_NOP));
            chk("idle_ready", int'(req_ready), 0);
            chk("idle_ack", int'(ref_ack), 0);
        end

        access(13'h012, 9'h034, 1'b0, 1'b0);   // closed row: ACT, RD
        access(13'h012, 9'h040, 1'b1, 1'b0);   // hit: WR only
        access(13'h099, 9'h0A5, 1'b0, 1'b0);   // miss: PRE, ACT, RD
        access(13'h099, 9'h1FF, 1'b1, 1'b0);   // hit on new row
        repeat (3) @(negedge clk);
        access(13'h055, 9'h066, 1'b0, 1'b1);   // refresh wins, then ACT, RD

        // Reset between ACT and RD of a row miss.
        req_row = 13'h1AB; req_col = 9'h011; req_we = 1'b0; req_valid = 1'b1;
        e0 = (cyc + 1 > next_e0) ? cyc + 1 : next_e0;
        push(e0, CMD_PRE, '0, '0);
        push(e0 + TRP, CMD_ACT, 13'h1AB, '0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc != e0 + TRP && n < 60);
        if (n >= 60) chk("act_timeout", 0, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_cmd", int'(cmd), int'(CMD_NOP));
        chk("async_rst_ready", int'(req_ready), 0);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_open  = 1'b0;
        next_e0 = 0;
        repeat (3) @(negedge clk);
        access(13'h1AB, 9'h011, 1'b0, 1'b0);   // must re-ACT after reset

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (TBURST + 2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
